// File: rtl/ibex_rf_wb_pkg.sv
// ibex_rf_wb_pkg: shared types and constants for the register-file writeback buffer
package ibex_rf_wb_pkg;
    localparam int unsigned RfWbDataWidth = 32;
    localparam logic [4:0] RegZero = 5'd0;
    typedef struct packed {
        logic                     valid;
        logic [4:0]               addr;
        logic [RfWbDataWidth-1:0] data;
    } rf_wb_entry_t;
    typedef enum logic {RfWbRun, RfWbDrain} rf_wb_state_e;
endpackage

// File: rtl/ibex_rf_wb_fwd_match.sv
// ibex_rf_wb_fwd_match: youngest-match selector over the queued writes for one read port
module ibex_rf_wb_fwd_match
    import ibex_rf_wb_pkg::*;
#(
    parameter int unsigned Depth     = 4,
    parameter int unsigned DataWidth = 32,
    localparam int unsigned PtrW     = $clog2(Depth)
) (
    input  logic [Depth-1:0]     valid_i,
    input  logic [4:0]           addr_i [Depth],
    input  logic [DataWidth-1:0] data_i [Depth],
    input  logic [PtrW-1:0]      rptr_i,
    input  logic [4:0]           raddr_i,
    output logic                 hit_o,
    output logic [DataWidth-1:0] data_o
);
    // Walk oldest to youngest from the head so the last hit is the youngest one.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        for (int k = 0; k < Depth; k++) begin
            if (valid_i[rptr_i + PtrW'(k)] && addr_i[rptr_i + PtrW'(k)] == raddr_i &&
                raddr_i != RegZero) begin
                hit_o  = 1'b1;
                data_o = data_i[rptr_i + PtrW'(k)];
            end
        end
    end
endmodule

// File: rtl/ibex_rf_wb_buffer.sv
// ibex_rf_wb_buffer: in-order write queue in front of the register file with read forwarding
module ibex_rf_wb_buffer
    import ibex_rf_wb_pkg::*;
#(
    parameter int unsigned Depth     = 4,
    parameter int unsigned DataWidth = 32,
    parameter bit          RV32E     = 1'b0
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       wb_valid_i,
    output logic                       wb_ready_o,
    input  logic [4:0]                 wb_addr_i,
    input  logic [DataWidth-1:0]       wb_data_i,
    input  logic                       flush_i,
    output logic                       drain_done_o,
    input  logic                       rf_stall_i,
    output logic                       rf_we_o,
    output logic [4:0]                 rf_waddr_o,
    output logic [DataWidth-1:0]       rf_wdata_o,
    input  logic [4:0]                 raddr_a_i,
    input  logic [4:0]                 raddr_b_i,
    output logic                       fwd_a_valid_o,
    output logic                       fwd_b_valid_o,
    output logic [DataWidth-1:0]       fwd_a_data_o,
    output logic [DataWidth-1:0]       fwd_b_data_o,
    output logic                       empty_o,
    output logic [$clog2(Depth):0]     count_o,
    output logic                       addr_err_o
);
    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    rf_wb_state_e         state_q, state_d;
    logic [PtrW-1:0]      wptr_q, rptr_q;
    logic [CntW-1:0]      count_q, count_d;
    logic [Depth-1:0]     valid_q;
    logic [4:0]           addr_q [Depth];
    logic [DataWidth-1:0] data_q [Depth];
    logic                 empty, full, accept, addr_bad, store, pop;
    logic                 done_d, drain_done_q, addr_err_q;

    assign empty    = count_q == '0;
    assign full     = count_q == CntW'(Depth);
    assign accept   = wb_valid_i && wb_ready_o;
    assign addr_bad = RV32E && wb_addr_i[4];
    assign store    = accept && wb_addr_i != RegZero && !addr_bad;
    assign rf_we_o  = !empty && !rf_stall_i;
    assign pop      = rf_we_o;
    assign count_d  = count_q + CntW'(store) - CntW'(pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= RfWbRun;
            drain_done_q <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            drain_done_q <= done_d;
            addr_err_q   <= accept && addr_bad;
        end
    end

    // A flush that finds the queue already empty finishes at once without visiting DRAIN.
    always_comb begin
        state_d = (state_q == RfWbDrain || flush_i) && count_d != '0 ? RfWbDrain : RfWbRun;
    end

    always_comb begin
        wb_ready_o = !full && state_q == RfWbRun;
        done_d     = (state_q == RfWbDrain || flush_i) && count_d == '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (pop) begin
                valid_q[rptr_q] <= 1'b0;
                rptr_q          <= rptr_q + 1'b1;
            end
            if (store) begin
                valid_q[wptr_q] <= 1'b1;
                wptr_q          <= wptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // Payload needs no reset: valid_q and the empty mask gate every use of it.
    always_ff @(posedge clk_i) begin
        if (store) begin
            addr_q[wptr_q] <= wb_addr_i;
            data_q[wptr_q] <= wb_data_i;
        end
    end

    assign rf_waddr_o   = empty ? RegZero : addr_q[rptr_q];
    assign rf_wdata_o   = empty ? '0 : data_q[rptr_q];
    assign empty_o      = empty;
    assign count_o      = count_q;
    assign drain_done_o = drain_done_q;
    assign addr_err_o   = addr_err_q;

    ibex_rf_wb_fwd_match #(.Depth(Depth), .DataWidth(DataWidth)) u_fwd_a (
        .valid_i (valid_q),
        .addr_i  (addr_q),
        .data_i  (data_q),
        .rptr_i  (rptr_q),
        .raddr_i (raddr_a_i),
        .hit_o   (fwd_a_valid_o),
        .data_o  (fwd_a_data_o)
    );

    ibex_rf_wb_fwd_match #(.Depth(Depth), .DataWidth(DataWidth)) u_fwd_b (
        .valid_i (valid_q),
        .addr_i  (addr_q),
        .data_i  (data_q),
        .rptr_i  (rptr_q),
        .raddr_i (raddr_b_i),
        .hit_o   (fwd_b_valid_o),
        .data_o  (fwd_b_data_o)
    );
endmodule

// File: tb/tb_ibex_rf_wb_buffer.sv
// tb_ibex_rf_wb_buffer: directed self-checking bench for the writeback buffer
module tb_ibex_rf_wb_buffer;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        wb_valid_i = 1'b0;
    logic        wb_ready_o;
    logic [4:0]  wb_addr_i = '0;
    logic [31:0] wb_data_i = '0;
    logic        flush_i = 1'b0;
    logic        drain_done_o;
    logic        rf_stall_i = 1'b0;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic [4:0]  raddr_a_i = '0;
    logic [4:0]  raddr_b_i = '0;
    logic        fwd_a_valid_o, fwd_b_valid_o;
    logic [31:0] fwd_a_data_o, fwd_b_data_o;
    logic        empty_o;
    logic [2:0]  count_o;
    logic        addr_err_o;
    int          tests = 0;
    int          fails = 0;

    ibex_rf_wb_buffer #(.Depth(4), .DataWidth(32), .RV32E(1'b1)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .wb_valid_i    (wb_valid_i),
        .wb_ready_o    (wb_ready_o),
        .wb_addr_i     (wb_addr_i),
        .wb_data_i     (wb_data_i),
        .flush_i       (flush_i),
        .drain_done_o  (drain_done_o),
        .rf_stall_i    (rf_stall_i),
        .rf_we_o       (rf_we_o),
        .rf_waddr_o    (rf_waddr_o),
        .rf_wdata_o    (rf_wdata_o),
        .raddr_a_i     (raddr_a_i),
        .raddr_b_i     (raddr_b_i),
        .fwd_a_valid_o (fwd_a_valid_o),
        .fwd_b_valid_o (fwd_b_valid_o),
        .fwd_a_data_o  (fwd_a_data_o),
        .fwd_b_data_o  (fwd_b_data_o),
        .empty_o       (empty_o),
        .count_o       (count_o),
        .addr_err_o    (addr_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        wb_valid_i = 1'b1;
        wb_addr_i  = a;
        wb_data_i  = d;
        step();
        wb_valid_i = 1'b0;
        #1;
    endtask

    initial begin
        #2;
        check("rst_ready", wb_ready_o, 1);
        check("rst_empty", empty_o, 1);
        check("rst_we", rf_we_o, 0);
        check("rst_count", count_o, 0);
        check("rst_waddr", rf_waddr_o, 0);
        check("rst_wdata", rf_wdata_o, 0);
        check("rst_fwd", {fwd_a_valid_o, fwd_b_valid_o, fwd_a_data_o, fwd_b_data_o}, 0);
        check("rst_pulses", {drain_done_o, addr_err_o}, 0);
        step();
        step();
        rst_ni = 1'b1;
        step();

        raddr_a_i = 5'd5;
        push(5'd5, 32'hDEADBEEF);
        check("single_we", rf_we_o, 1);
        check("single_waddr", rf_waddr_o, 5);
        check("single_wdata", rf_wdata_o, 32'hDEADBEEF);
        check("single_head_fwd", {fwd_a_valid_o, fwd_a_data_o}, {1'b1, 32'hDEADBEEF});
        step();
        check("single_empty", empty_o, 1);
        check("single_we_off", rf_we_o, 0);

        rf_stall_i = 1'b1;
        for (int i = 1; i <= 4; i++) push(5'(i), 32'(i * 'h11));
        check("fill_count", count_o, 4);
        check("fill_ready", wb_ready_o, 0);
        check("fill_we_stalled", rf_we_o, 0);
        rf_stall_i = 1'b0;
        #1;
        check("fill_ready_no_pop_path", wb_ready_o, 0);
        for (int i = 1; i <= 4; i++) begin
            check("drain_we", rf_we_o, 1);
            check("drain_waddr", rf_waddr_o, 5'(i));
            check("drain_wdata", rf_wdata_o, 32'(i * 'h11));
            step();
        end
        check("drain_empty", empty_o, 1);

        rf_stall_i = 1'b1;
        raddr_a_i  = 5'd7;
        raddr_b_i  = 5'd0;
        push(5'd7, 32'hA);
        check("fwd_one", {fwd_a_valid_o, fwd_a_data_o}, {1'b1, 32'hA});
        push(5'd7, 32'hB);
        check("fwd_youngest", {fwd_a_valid_o, fwd_a_data_o}, {1'b1, 32'hB});
        check("fwd_x0", {fwd_b_valid_o, fwd_b_data_o}, 0);
        rf_stall_i = 1'b0;
        #1;
        check("fwd_pop_old", rf_wdata_o, 32'hA);
        check("fwd_still_young", fwd_a_data_o, 32'hB);
        step();
        check("fwd_pop_young", {rf_waddr_o, rf_wdata_o}, {5'd7, 32'hB});
        check("fwd_head_match", {fwd_a_valid_o, fwd_a_data_o}, {1'b1, 32'hB});
        step();
        check("fwd_gone", fwd_a_valid_o, 0);

        check("x0_ready", wb_ready_o, 1);
        push(5'd0, 32'h123);
        check("x0_count", count_o, 0);
        check("x0_no_err", {addr_err_o, rf_we_o}, 0);
        push(5'd20, 32'h55);
        check("e_err", addr_err_o, 1);
        check("e_dropped", {count_o, rf_we_o}, 0);
        step();
        check("e_err_once", addr_err_o, 0);

        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        #1;
        check("flush_empty_done", {drain_done_o, wb_ready_o}, 2'b11);
        step();
        check("flush_empty_done_once", drain_done_o, 0);

        rf_stall_i = 1'b1;
        for (int i = 1; i <= 3; i++) push(5'(i), 32'(i));
        flush_i    = 1'b1;
        rf_stall_i = 1'b0;
        #1;
        check("flush_pre", {wb_ready_o, count_o}, {1'b1, 3'd3});
        step();
        flush_i    = 1'b0;
        wb_valid_i = 1'b1;
        wb_addr_i  = 5'd9;
        wb_data_i  = 32'd99;
        #1;
        check("flush_d1", {wb_ready_o, drain_done_o, count_o, rf_waddr_o}, {2'b00, 3'd2, 5'd2});
        step();
        check("flush_d2", {wb_ready_o, drain_done_o, count_o, rf_waddr_o}, {2'b00, 3'd1, 5'd3});
        step();
        wb_valid_i = 1'b0;
        #1;
        check("flush_done", {wb_ready_o, drain_done_o, empty_o, rf_we_o}, 4'b1110);
        step();
        check("flush_done_once", {drain_done_o, count_o}, 0);

        rf_stall_i = 1'b1;
        raddr_a_i  = 5'd3;
        push(5'd3, 32'h33);
        push(5'd4, 32'h44);
        check("mid_count", count_o, 2);
        step();
        rf_stall_i = 1'b0;
        #1;
        check("mid_we_before", {rf_we_o, rf_waddr_o}, {1'b1, 5'd3});
        rst_ni = 1'b0;
        #1;
        check("mid_rst_we", rf_we_o, 0);
        check("mid_rst_state", {count_o, empty_o, wb_ready_o}, {3'd0, 2'b11});
        check("mid_rst_fwd", {fwd_a_valid_o, rf_waddr_o}, 0);
        step();
        check("mid_rst_hold", rf_we_o, 0);
        rst_ni = 1'b1;
        step();
        check("mid_after", {rf_we_o, empty_o, count_o}, {2'b01, 3'd0});
        step();
        check("mid_never_issued", rf_we_o, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
